// File: rtl/tap_bypass_register_if.sv
// Serial scan-path signals between the TAP data-register mux and the BYPASS register.
interface tap_bypass_register_if;
    logic tdi_i;
    logic bypassEna_i;
    logic tdo_o;

    modport master (
        output tdi_i,
        output bypassEna_i,
        input  tdo_o
    );

    modport slave (
        input  tdi_i,
        input  bypassEna_i,
        output tdo_o
    );
endinterface

// File: rtl/tap_bypass_register.sv
// Single-bit JTAG BYPASS data register: one TCK stage from tdi to tdo while selected,
// cleared to zero whenever deselected so the first bit shifted out is always 0.
module tap_bypass_register (
    input  logic                        tck_i,
    input  logic                        trst_ni,
    tap_bypass_register_if.slave        bus
);

    logic bypass_q;

    // Reset outranks enable; a deselected register loads 0, giving the capture-zero behaviour.
    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            bypass_q <= 1'b0;
        end else if (bus.bypassEna_i) begin
            bypass_q <= bus.tdi_i;
        end else begin
            bypass_q <= 1'b0;
        end
    end

    assign bus.tdo_o = bypass_q;

endmodule

// File: tb/tb_tap_bypass_register.sv
// Directed-vector bench for the BYPASS register: reset, shifting, latency, disable and priority.
`timescale 1ns/1ps
module tb_tap_bypass_register;

    logic tck;
    logic trst_n;
    int   n_checks;
    int   n_errors;

    tap_bypass_register_if bus ();

    tap_bypass_register dut (
        .tck_i   (tck),
        .trst_ni (trst_n),
        .bus     (bus.slave)
    );

    initial tck = 1'b0;
    always #18.52 tck = ~tck;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge tck);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] word;
        logic [4:0] lat_seq;
        logic       prev;

        n_checks        = 0;
        n_errors        = 0;
        pat             = 8'b10101011;
        lat_seq         = 5'b10110;   // LSB first: 0,1,1,0,1
        trst_n          = 1'b0;
        bus.bypassEna_i = 1'b1;
        bus.tdi_i       = 1'b1;

        // Reset held with enable and tdi high
        step(); check("reset_edge1", {7'b0, bus.tdo_o}, 8'h00);
        step(); check("reset_edge2", {7'b0, bus.tdo_o}, 8'h00);

        // Pattern shift, LSB first
        trst_n = 1'b1;
        word   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus.tdi_i = pat[i];
            step();
            check($sformatf("shift_bit%0d", i), {7'b0, bus.tdo_o}, {7'b0, pat[i]});
            word[i] = bus.tdo_o;
        end
        check("shift_word", word, 8'b10101011);

        // Latency: value seen just before edge N+1 equals tdi sampled at edge N
        for (int i = 0; i < 5; i++) begin
            bus.tdi_i = lat_seq[i];
            prev      = lat_seq[i];
            step();
            bus.tdi_i = ~prev;
            @(negedge tck);
            check($sformatf("latency_%0d", i), {7'b0, bus.tdo_o}, {7'b0, prev});
        end

        // Disable clears and holds zero; re-enable shifts immediately
        bus.tdi_i = 1'b1;
        step(); check("pre_disable", {7'b0, bus.tdo_o}, 8'h01);
        bus.bypassEna_i = 1'b0;
        step(); check("disable_edge", {7'b0, bus.tdo_o}, 8'h00);
        step(); check("disable_hold1", {7'b0, bus.tdo_o}, 8'h00);
        step(); check("disable_hold2", {7'b0, bus.tdo_o}, 8'h00);
        bus.bypassEna_i = 1'b1;
        step(); check("reenable_first", {7'b0, bus.tdo_o}, 8'h01);
        bus.tdi_i = 1'b0;
        step(); check("reenable_second", {7'b0, bus.tdo_o}, 8'h00);

        // Reset mid-shift while streaming ones
        bus.tdi_i = 1'b1;
        step(); check("midshift_before", {7'b0, bus.tdo_o}, 8'h01);
        trst_n = 1'b0;
        step(); check("midshift_reset", {7'b0, bus.tdo_o}, 8'h00);
        trst_n = 1'b1;
        step(); check("midshift_resume", {7'b0, bus.tdo_o}, 8'h01);

        // Reset outranks enable
        trst_n = 1'b0;
        step(); check("priority", {7'b0, bus.tdo_o}, 8'h00);
        trst_n = 1'b1;
        step(); check("priority_release", {7'b0, bus.tdo_o}, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
